nibble_serial_adder: RTL and testbench
======================================

// Module: nibble_serial_adder
// PURPOSE
//  Sequencing stage that feeds the 4-bit ripple-carry adder (adder4: A,B,cin -> S,cout)
//  and consumes its result, extending it to NIBBLES*4-bit operands.
//  One nibble is added per clock, least-significant nibble first, with carry held in a register.
//  Sits between an upstream operand source and a downstream result sink; both sides use valid/ready.
//  Instantiates exactly one adder4 internally.
// PARAMETERS
//  NIBBLES  4  operand width in nibbles; W = 4*NIBBLES; legal range 1..16
// PORTS
//  clk        in   1  single clock; all state updates on the rising edge
//  rst        in   1  synchronous, active-high reset
//  in_valid   in   1  upstream has an operand pair on op_a/op_b/cin
//  in_ready   out  1  block can accept an operand pair
//  op_a       in   W  operand A, unsigned or two's complement
//  op_b       in   W  operand B
//  cin        in   1  carry-in to the least-significant nibble
//  out_valid  out  1  sum/cout/ovf hold a completed result
//  out_ready  in   1  downstream accepts the result
//  sum        out  W  op_a + op_b + cin, modulo 2^W
//  cout       out  1  carry out of the most-significant nibble
//  ovf        out  1  signed overflow: a_msb==b_msb && sum_msb!=a_msb
// BEHAVIOUR
//  Reset (rst=1 at an edge):
//   - State goes to IDLE; in_ready=1, out_valid=0, sum=0, cout=0, ovf=0.
//   - Carry, nibble counter and operand registers are cleared.
//   - Reset dominates every other input, including mid-ADD and mid-DONE.
//   - An aborted operation never produces out_valid.
//  States:
//   - IDLE: in_ready=1. On in_valid&&in_ready, latch op_a, op_b, carry<=cin, a_msb, b_msb, cnt<=0; go to ADD.
//   - ADD: in_ready=0, out_valid=0. adder4 is driven with A=a_reg[3:0], B=b_reg[3:0], cin=carry.
//     Each edge: sum_reg<={S,sum_reg[W-1:4]}; a_reg>>=4; b_reg>>=4; carry<=cout; cnt<=cnt+1.
//     The edge where cnt==NIBBLES-1 goes to DONE.
//   - DONE: out_valid=1; sum, cout=carry, ovf are registered and held stable.
//     On out_valid&&out_ready, go to IDLE.
//  Timing:
//   - Latency: accept edge k; out_valid is high after edge k+NIBBLES.
//   - NIBBLES=1 gives out_valid one cycle after accept.
//   - Max throughput is one operation per NIBBLES+2 cycles; there is no overlap of ops.
//  Handshake rules:
//   - in_valid while not IDLE is ignored; no operand is captured or queued.
//   - Upstream must hold operands stable only until the accept edge.
//   - out_valid stays high with unchanged outputs while out_ready=0 (no timeout).
//   - If out_ready is already high on entering DONE, out_valid is high for exactly one cycle.
//   - in_ready rises the cycle after the output handshake; it is never combinationally tied to out_ready.
//  Arithmetic:
//   - W-bit wrap-around; carry propagates nibble to nibble through the carry register only.
//   - No combinational path from op_a/op_b/cin to any output.
//  Outputs:
//   - All outputs are registered, including in_ready/out_valid decoded from the state register.
//   - sum is undefined-free: it holds its previous value outside DONE.
// TESTING
//  (NIBBLES=4 unless stated)
//  1. Reset: rst=1 for 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, sum=0, cout=0, ovf=0; nothing captured.
//  2. 0x1234+0x1111, cin=0 -> out_valid exactly 4 cycles after accept; sum=0x2345, cout=0, ovf=0.
//  3. 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry ripples through all 4 nibbles).
//  4. 0x7FFF+0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; 0x8000+0x8000 -> sum=0x0000, cout=1, ovf=1.
//  5. Backpressure: out_ready=0 for 5 cycles with in_valid pulsing -> out_valid/sum held, in_ready=0, no capture;
//     then out_ready=1 -> in_ready=1 next cycle, next op accepted.
//  6. rst=1 during the 2nd ADD cycle -> next cycle IDLE, out_valid never rises;
//     then 0xFFFF+0xFFFF, cin=1 -> sum=0xFFFF, cout=1, ovf=0. Repeat case 2 with NIBBLES=1 (0x9+0x8 -> 0x1, cout=1).

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: one 4-bit ripple-carry slice reused over NIBBLES clocks,
// LS nibble first, carry held in a register between nibbles.

module adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] c;

  assign c[0] = cin;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_fa
      assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = c[4];
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 ovf
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t          state_reg, state_next;
  logic [W-1:0]    a_reg, b_reg;
  logic            carry_reg;
  logic [CW-1:0]   cnt_reg;
  logic            a_msb_reg, b_msb_reg;
  logic [W-1:0]    sum_reg;
  logic            cout_reg, ovf_reg;

  logic [3:0]      add_s;
  logic            add_cout;
  logic [W-1:0]    acc_shift;
  logic            last_nibble;
  logic            accept;

  adder4 u_adder4 (
    .a    (a_reg[3:0]),
    .b    (b_reg[3:0]),
    .cin  (carry_reg),
    .s    (add_s),
    .cout (add_cout)
  );

  assign accept      = in_valid && (state_reg == IDLE);
  assign last_nibble = (cnt_reg == CW'(NIBBLES - 1));

  // Partial sum keeps only the upper W-4 bits; the lowest slot is always the
  // nibble being produced this cycle, so it never needs storage.
  generate
    if (NIBBLES == 1) begin : g_acc_none
      assign acc_shift = add_s;
    end else begin : g_acc
      logic [W-5:0] acc_reg;
      assign acc_shift = {add_s, acc_reg};
      always_ff @(posedge clk) begin
        if (rst || accept) begin
          acc_reg <= '0;
        end else if (state_reg == ADD) begin
          acc_reg <= acc_shift[W-1:4];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = ADD;
      ADD:     if (last_nibble) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      if (accept) begin
        a_reg     <= op_a;
        b_reg     <= op_b;
        carry_reg <= cin;
        cnt_reg   <= '0;
        a_msb_reg <= op_a[W-1];
        b_msb_reg <= op_b[W-1];
      end else if (state_reg == ADD) begin
        a_reg     <= a_reg >> 4;
        b_reg     <= b_reg >> 4;
        carry_reg <= add_cout;
        cnt_reg   <= cnt_reg + CW'(1);
        // Result registers only change on the final nibble so they hold
        // the previous result through IDLE and ADD.
        if (last_nibble) begin
          sum_reg  <= acc_shift;
          cout_reg <= add_cout;
          ovf_reg  <= (a_msb_reg == b_msb_reg) && (add_s[3] != a_msb_reg);
        end
      end
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign ovf       = ovf_reg;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: a 4-nibble instance for the main
// cases and a 1-nibble instance for the minimum-width case.

module tb_nibble_serial_adder;
  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid, in_ready, out_valid, out_ready, cin, cout, ovf;
  logic [15:0] op_a, op_b, sum;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1, ovf1;
  logic [3:0]  op_a1, op_b1, sum1;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .op_a(op_a1), .op_b(op_b1), .cin(cin1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one operation on the 4-nibble instance and check latency and result.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic rdy, input logic [15:0] exp_sum,
                        input logic exp_cout, input logic exp_ovf);
    int lat;
    out_ready = rdy;
    op_a = a; op_b = b; cin = c; in_valid = 1'b1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; op_a = 16'hDEAD; op_b = 16'hBEEF; cin = 1'b1;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
    check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    check({tag, "_busy"}, 32'(in_ready), 32'd0);
    $display("op %s: %h + %h + %0d -> sum=%h cout=%0d ovf=%0d latency=%0d",
             tag, a, b, c, sum, cout, ovf, lat);
    if (!rdy) begin
      @(negedge clk);
      check({tag, "_hold"}, 32'(out_valid), 32'd1);
      out_ready = 1'b1;
    end
    @(negedge clk);
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int highs;
    rst = 1'b1;
    in_valid = 1'b1; op_a = 16'h1234; op_b = 16'h1111; cin = 1'b0; out_ready = 1'b0;
    in_valid1 = 1'b0; op_a1 = 4'h0; op_b1 = 4'h0; cin1 = 1'b0; out_ready1 = 1'b0;

    // Reset held two cycles with in_valid asserted.
    repeat (2) @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    check("rst_nocapture", 32'(in_ready), 32'd1);

    run_op("add_basic", 16'h1234, 16'h1111, 1'b0, 1'b1, 16'h2345, 1'b0, 1'b0);
    run_op("ripple",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("ovf_pos",   16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
    run_op("ovf_neg",   16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);
    run_op("cin_only",  16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0);

    // Backpressure: result held for 5 cycles while in_valid pulses with other operands.
    out_ready = 1'b0;
    op_a = 16'h00FF; op_b = 16'h0F01; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_sum", 32'(sum), 32'h1000);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0); op_a = 16'h1111; op_b = 16'h2222;
      @(negedge clk);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_sum", 32'(sum), 32'h1000);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_sum_held", 32'(sum), 32'h1000);
    run_op("after_bp", 16'h0001, 16'h0002, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b0);

    // Reset during the second ADD cycle aborts the operation.
    op_a = 16'h1234; op_b = 16'h1111; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_sum", 32'(sum), 32'd0);
    highs = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) highs++;
      @(negedge clk);
    end
    check("abort_no_valid", 32'(highs), 32'd0);
    run_op("all_ones", 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0);

    // Single-nibble instance: result one cycle after accept.
    op_a1 = 4'h9; op_b1 = 4'h8; cin1 = 1'b0; in_valid1 = 1'b1;
    check("n1_in_ready", 32'(in_ready1), 32'd1);
    @(negedge clk);
    in_valid1 = 1'b0;
    check("n1_busy", 32'(in_ready1), 32'd0);
    @(negedge clk);
    check("n1_valid", 32'(out_valid1), 32'd1);
    check("n1_sum", 32'(sum1), 32'h1);
    check("n1_cout", 32'(cout1), 32'd1);
    check("n1_ovf", 32'(ovf1), 32'd1);
    $display("op n1: 9 + 8 + 0 -> sum=%h cout=%0d ovf=%0d", sum1, cout1, ovf1);
    out_ready1 = 1'b1;
    @(negedge clk);
    check("n1_valid_drop", 32'(out_valid1), 32'd0);
    check("n1_ready_back", 32'(in_ready1), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
